// File: rtl/ps2_color_selector.sv
// ps2_color_selector: turns a PS/2 set-2 scan-code byte stream into a held
// colour index. Tracks break (F0) and extended (E0) prefixes, latches the
// index of the last pressed number-row key, and pulses value_strobe once per
// accepted selection. Requires 2**COLOR_W >= KEY_COUNT and KEY_COUNT in 1..10.
module ps2_color_selector #(
    parameter int                 KEY_COUNT       = 8,
    parameter int                 COLOR_W         = 3,
    parameter logic [COLOR_W-1:0] RESET_COLOR     = '0,
    parameter bit                 REPEAT_SUPPRESS = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan_valid,
    input  logic [7:0]         scan_code,
    output logic [COLOR_W-1:0] value,
    output logic               value_strobe,
    output logic               key_held
);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    // Number row 1..9, 0; the key index is the position in this table.
    localparam logic [9:0][7:0] KEY_CODES = {
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic [COLOR_W-1:0] value_q, value_d;
    logic               strobe_q, strobe_d;
    logic               held_q, held_d;
    logic [7:0]         held_code_q, held_code_d;

    logic               key_hit;
    logic [COLOR_W-1:0] key_idx;

    // Map the incoming byte to a key index; codes past KEY_COUNT never hit.
    always_comb begin
        key_hit = 1'b0;
        key_idx = '0;
        for (int k = 0; k < KEY_COUNT; k++) begin
            if (scan_code == KEY_CODES[k]) begin
                key_hit = 1'b1;
                key_idx = COLOR_W'(k);
            end
        end
    end

    // State and output registers; reset drops any byte presented with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            value_q     <= RESET_COLOR;
            strobe_q    <= 1'b0;
            held_q      <= 1'b0;
            held_code_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            strobe_q    <= strobe_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
        end
    end

    // Prefix tracking: every valid byte is consumed by exactly one state.
    always_comb begin
        state_d = state_q;
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code == CODE_BREAK)     state_d = S_BREAK;
                    else if (scan_code == CODE_EXT)  state_d = S_EXT;
                end
                S_BREAK:     state_d = S_IDLE;
                S_EXT:       state_d = (scan_code == CODE_BREAK) ? S_EXT_BREAK : S_IDLE;
                S_EXT_BREAK: state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Selection and release: only plain makes select, only plain breaks of
    // the held key release it; extended sequences change nothing.
    always_comb begin
        value_d     = value_q;
        strobe_d    = 1'b0;
        held_d      = held_q;
        held_code_d = held_code_q;
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    // F0/E0 are never key codes, so key_hit excludes prefixes.
                    if (key_hit &&
                        !(REPEAT_SUPPRESS && held_q && (scan_code == held_code_q))) begin
                        value_d     = key_idx;
                        strobe_d    = 1'b1;
                        held_d      = 1'b1;
                        held_code_d = scan_code;
                    end
                end
                S_BREAK: begin
                    // Break of an older, superseded key does not match held_code.
                    if (held_q && (scan_code == held_code_q)) held_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign value        = value_q;
    assign value_strobe = strobe_q;
    assign key_held     = held_q;

endmodule

// File: tb/tb_ps2_color_selector.sv
// Bench for ps2_color_selector: three instances (default, no repeat
// suppression, ten keys) share one stimulus stream and are compared against
// a byte-level reference model of the scan-code protocol.
module tb_ps2_color_selector;

    logic       clk;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_code;

    logic [2:0] v0, v1;
    logic [3:0] v2;
    logic       s0, s1, s2, h0, h1, h2;

    int errors = 0;
    int checks = 0;

    ps2_color_selector dut0 (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .value(v0), .value_strobe(s0), .key_held(h0)
    );

    ps2_color_selector #(.REPEAT_SUPPRESS(1'b0)) dut1 (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .value(v1), .value_strobe(s1), .key_held(h1)
    );

    ps2_color_selector #(.KEY_COUNT(10), .COLOR_W(4)) dut2 (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .value(v2), .value_strobe(s2), .key_held(h2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, one slot per instance.
    logic [7:0] codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                               8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    int kc [3] = '{8, 8, 10};
    bit rs [3] = '{1'b1, 1'b0, 1'b1};
    int m_val [3];
    int m_hcode [3];
    bit m_stb [3], m_held [3], m_brk [3], m_ext [3], m_skip [3];
    int nstb [3];

    task automatic model_reset(input int c);
        m_val[c] = 0; m_hcode[c] = 0; m_stb[c] = 0; m_held[c] = 0;
        m_brk[c] = 0; m_ext[c] = 0; m_skip[c] = 0;
    endtask

    task automatic model_step(input int c, input logic [7:0] b);
        int k;
        k = -1;
        for (int i = 0; i < kc[c]; i++) if (codes[i] == b) k = i;
        m_stb[c] = 0;
        if (m_brk[c]) begin
            m_brk[c] = 0;
            if (m_held[c] && m_hcode[c] == int'(b)) m_held[c] = 0;
        end else if (m_skip[c]) begin
            m_skip[c] = 0;
        end else if (m_ext[c]) begin
            m_ext[c] = 0;
            if (b == 8'hF0) m_skip[c] = 1;
        end else if (b == 8'hF0) begin
            m_brk[c] = 1;
        end else if (b == 8'hE0) begin
            m_ext[c] = 1;
        end else if (k >= 0 && !(rs[c] && m_held[c] && m_hcode[c] == int'(b))) begin
            m_val[c] = k; m_stb[c] = 1; m_held[c] = 1; m_hcode[c] = int'(b);
        end
    endtask

    // One clock: drive at the negedge, update the model at the posedge,
    // return at the next negedge with outputs settled.
    task automatic cyc(input bit v, input logic [7:0] b, input bit r);
        reset = r; scan_valid = v; scan_code = b;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (r) model_reset(c);
            else if (v) model_step(c, b);
            else m_stb[c] = 0;
        end
        @(negedge clk);
        reset = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
        if (s0 === 1'b1) nstb[0]++;
        if (s1 === 1'b1) nstb[1]++;
        if (s2 === 1'b1) nstb[2]++;
    endtask

    task automatic do_reset;
        cyc(1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 3; c++) nstb[c] = 0;
    endtask

    task automatic test_reset;
        cyc(1'b1, 8'h1E, 1'b1);
        checks++;
        if (v0 !== 3'd0 || s0 !== 1'b0 || h0 !== 1'b0 || v2 !== 4'd0 || s2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_byte: value=%0d strobe=%b held=%b (dut2 value=%0d strobe=%b), expected 0/0/0", v0, s0, h0, v2, s2);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            checks++;
            if (v0 !== 3'd0 || s0 !== 1'b0 || h0 !== 1'b0 ||
                v1 !== 3'd0 || s1 !== 1'b0 || h1 !== 1'b0 ||
                v2 !== 4'd0 || s2 !== 1'b0 || h2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle%0d: value=%0d/%0d/%0d strobe=%b%b%b held=%b%b%b, expected all 0",
                         i, v0, v1, v2, s0, s1, s2, h0, h1, h2);
            end
        end
    endtask

    task automatic test_repeat;
        do_reset;
        cyc(1'b1, 8'h1E, 1'b0);
        checks++;
        if (v0 !== 3'd1 || s0 !== 1'b1 || h0 !== 1'b1) begin
            errors++;
            $display("FAIL repeat_first: value=%0d strobe=%b held=%b, expected 1/1/1", v0, s0, h0);
        end
        cyc(1'b1, 8'h1E, 1'b0);
        cyc(1'b1, 8'h1E, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (nstb[0] != 1 || v0 !== 3'd1 || h0 !== 1'b1) begin
            errors++;
            $display("FAIL repeat_suppress: strobes=%0d value=%0d held=%b, expected 1 strobe value 1 held 1", nstb[0], v0, h0);
        end
        checks++;
        if (nstb[1] != 3 || v1 !== 3'd1) begin
            errors++;
            $display("FAIL repeat_nosuppress: strobes=%0d value=%0d, expected 3 strobes value 1", nstb[1], v1);
        end
    endtask

    task automatic test_break_remake;
        do_reset;
        cyc(1'b1, 8'h26, 1'b0);
        checks++;
        if (v0 !== 3'd2 || s0 !== 1'b1 || h0 !== 1'b1) begin
            errors++;
            $display("FAIL remake_make: value=%0d strobe=%b held=%b, expected 2/1/1", v0, s0, h0);
        end
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h26, 1'b0);
        checks++;
        if (h0 !== 1'b0 || s0 !== 1'b0 || v0 !== 3'd2) begin
            errors++;
            $display("FAIL remake_break: value=%0d strobe=%b held=%b, expected 2/0/0", v0, s0, h0);
        end
        cyc(1'b1, 8'h26, 1'b0);
        checks++;
        if (v0 !== 3'd2 || s0 !== 1'b1 || h0 !== 1'b1) begin
            errors++;
            $display("FAIL remake_again: value=%0d strobe=%b held=%b, expected 2/1/1", v0, s0, h0);
        end
    endtask

    task automatic test_overlap;
        do_reset;
        cyc(1'b1, 8'h2E, 1'b0);
        cyc(1'b1, 8'h3E, 1'b0);
        checks++;
        if (v0 !== 3'd7 || s0 !== 1'b1 || h0 !== 1'b1) begin
            errors++;
            $display("FAIL overlap_new: value=%0d strobe=%b held=%b, expected 7/1/1", v0, s0, h0);
        end
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h2E, 1'b0);
        checks++;
        if (h0 !== 1'b1 || v0 !== 3'd7) begin
            errors++;
            $display("FAIL overlap_oldbreak: value=%0d held=%b, expected 7/1", v0, h0);
        end
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h3E, 1'b0);
        checks++;
        if (h0 !== 1'b0 || v0 !== 3'd7) begin
            errors++;
            $display("FAIL overlap_newbreak: value=%0d held=%b, expected 7/0", v0, h0);
        end
    endtask

    task automatic test_extended;
        logic [7:0] seq [9] = '{8'hF0, 8'h1E, 8'hE0, 8'h16, 8'hE0, 8'hF0, 8'h16, 8'h1C, 8'h00};
        do_reset;
        cyc(1'b1, 8'h1E, 1'b0);
        for (int c = 0; c < 3; c++) nstb[c] = 0;
        for (int i = 0; i < 8; i++) cyc(1'b1, seq[i], 1'b0);
        checks++;
        if (nstb[0] != 0 || v0 !== 3'd1 || h0 !== 1'b0 || nstb[2] != 0) begin
            errors++;
            $display("FAIL ext_ignored: strobes=%0d value=%0d held=%b, expected 0 strobes value 1 held 0", nstb[0], v0, h0);
        end
        cyc(1'b1, 8'h16, 1'b0);
        checks++;
        if (v0 !== 3'd0 || s0 !== 1'b1 || h0 !== 1'b1) begin
            errors++;
            $display("FAIL ext_idle_after: value=%0d strobe=%b held=%b, expected 0/1/1", v0, s0, h0);
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        cyc(1'b1, 8'h16, 1'b0);
        cyc(1'b1, 8'h1E, 1'b0);
        checks++;
        if (v0 !== 3'd1 || s0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: value=%0d strobe=%b, expected 1/1", v0, s0);
        end
        cyc(1'b1, 8'h26, 1'b0);
        checks++;
        if (v0 !== 3'd2 || s0 !== 1'b1 || nstb[0] != 3) begin
            errors++;
            $display("FAIL b2b_third: value=%0d strobe=%b strobes=%0d, expected 2/1/3", v0, s0, nstb[0]);
        end
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (s0 !== 1'b0 || v0 !== 3'd2) begin
            errors++;
            $display("FAIL b2b_drop: value=%0d strobe=%b, expected 2/0", v0, s0);
        end
    endtask

    task automatic test_ten_keys;
        do_reset;
        cyc(1'b1, 8'h45, 1'b0);
        checks++;
        if (v2 !== 4'd9 || s2 !== 1'b1 || h2 !== 1'b1) begin
            errors++;
            $display("FAIL kc10_make: value=%0d strobe=%b held=%b, expected 9/1/1", v2, s2, h2);
        end
        checks++;
        if (s0 !== 1'b0 || h0 !== 1'b0 || v0 !== 3'd0) begin
            errors++;
            $display("FAIL kc8_unmapped: value=%0d strobe=%b held=%b, expected 0/0/0", v0, s0, h0);
        end
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h45, 1'b1);
        checks++;
        if (v2 !== 4'd0 || s2 !== 1'b0 || h2 !== 1'b0) begin
            errors++;
            $display("FAIL kc10_midreset: value=%0d strobe=%b held=%b, expected 0/0/0", v2, s2, h2);
        end
        cyc(1'b1, 8'h45, 1'b0);
        checks++;
        if (v2 !== 4'd9 || s2 !== 1'b1 || h2 !== 1'b1) begin
            errors++;
            $display("FAIL kc10_fresh: value=%0d strobe=%b held=%b, expected 9/1/1", v2, s2, h2);
        end
    endtask

    task automatic test_random;
        logic [7:0] pool [14] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46, 8'h45, 8'hF0, 8'hE0, 8'h1C, 8'h00};
        logic [3:0] av;
        logic       as, ah;
        logic [7:0] b;
        do_reset;
        for (int n = 0; n < 400; n++) begin
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
            cyc($urandom_range(0, 3) != 0, b, $urandom_range(0, 63) == 0);
            for (int c = 0; c < 3; c++) begin
                case (c)
                    0:       begin av = {1'b0, v0}; as = s0; ah = h0; end
                    1:       begin av = {1'b0, v1}; as = s1; ah = h1; end
                    default: begin av = v2;         as = s2; ah = h2; end
                endcase
                checks++;
                if (av !== 4'(m_val[c]) || as !== m_stb[c] || ah !== m_held[c]) begin
                    errors++;
                    $display("FAIL random dut%0d step%0d: value=%0d strobe=%b held=%b, expected value=%0d strobe=%b held=%b",
                             c, n, av, as, ah, m_val[c], m_stb[c], m_held[c]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00;
        for (int c = 0; c < 3; c++) begin model_reset(c); nstb[c] = 0; end
        test_reset;
        test_repeat;
        test_break_remake;
        test_overlap;
        test_extended;
        test_back_to_back;
        test_ten_keys;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
